// File: rtl/uart_rx_8n1.sv
// ============================================================================
// Module      : uart_rx_8n1
// Description : 8N1 UART receiver (LSB first) with a mid-bit sampling FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       en,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t      state, state_next;
    logic        rx_meta, rx_s;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  idx, idx_next;
    logic [7:0]  shreg, shreg_next;
    logic [7:0]  data_next;
    logic        en_next, ferr_next, busy_next;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            en        <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shreg     <= shreg_next;
            data      <= data_next;
            en        <= en_next;
            frame_err <= ferr_next;
            busy      <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 16'd1;
        idx_next   = idx;
        shreg_next = shreg;
        data_next  = data;
        en_next    = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = 16'd0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = 16'd0;
                    idx_next   = 3'd0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next        = 16'd0;
                    shreg_next[idx] = rx_s;
                    idx_next        = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets an immediately following start edge be caught.
                if (cnt == BIT_LAST) begin
                    cnt_next = 16'd0;
                    if (rx_s) begin
                        data_next  = shreg;
                        en_next    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_next = 16'd0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = 16'd0;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

`default_nettype wire
